// File: rtl/thor2023_dcache_line_fill.sv
// thor2023_dcache_line_fill: data-cache miss handler that assembles 512-bit lines from Wishbone bursts
//
// Fills the addressed line and, for accesses spanning two lines, the following line.
// Optional macro THOR2023_DCFILL_TIMEOUT_EN: an 8-bit counter aborts a burst that waits
// TO_CNT cycles without an ack, exactly as if err_i had been seen.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   req_v/req_rdy/req_adr/req_vadr/req_span : fill request handshake
//   cyc_o/stb_o/we_o/sel_o/cti_o/adr_o      : Wishbone master, incrementing bursts
//   dat_i/ack_i/err_i                       : Wishbone read data and responses
//   line_o        : {v,m,vtag,ptag,data} image, held until the next write
//   update_adr_o  : line-aligned virtual address of line_o
//   wr_dc_o       : one-cycle cache write strobe
//   done_o/err_o  : one-cycle completion / abort pulses
module thor2023_dcache_line_fill #(
    parameter int BUS_WID  = 128,
    parameter int LINE_WID = 512,
    parameter int ADR_WID  = 32,
    parameter int LOBIT    = 6
`ifdef THOR2023_DCFILL_TIMEOUT_EN
    ,
    parameter int TO_CNT   = 255
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_v,
    output logic                            req_rdy,
    input  logic [ADR_WID-1:0]              req_adr,
    input  logic [ADR_WID-1:0]              req_vadr,
    input  logic                            req_span,
    output logic                            cyc_o,
    output logic                            stb_o,
    output logic                            we_o,
    output logic [BUS_WID/8-1:0]            sel_o,
    output logic [2:0]                      cti_o,
    output logic [ADR_WID-1:0]              adr_o,
    input  logic [BUS_WID-1:0]              dat_i,
    input  logic                            ack_i,
    input  logic                            err_i,
    output logic [LINE_WID+2*ADR_WID+1:0]   line_o,
    output logic [ADR_WID-1:0]              update_adr_o,
    output logic                            wr_dc_o,
    output logic                            done_o,
    output logic                            err_o
);
    localparam int BEATS = LINE_WID / BUS_WID;
    localparam int BW    = $clog2(BEATS);
    localparam int OFFB  = $clog2(BUS_WID / 8);
    localparam int LW    = LINE_WID + 2 * ADR_WID + 2;
    localparam logic [ADR_WID-1:0] LINE_INC = ADR_WID'(1 << LOBIT);
    localparam logic [ADR_WID-1:0] AMASK    = ~(LINE_INC - 1'b1);

    typedef enum logic [2:0] {IDLE, BURST, WRITE, DONE, ABORT} state_t;

    state_t              state_q, state_d;
    logic [ADR_WID-1:0]  adr_q, vadr_q;
    logic [BW-1:0]       beat_q;
    logic [1:0]          lines_q;
    logic [LINE_WID-1:0] buf_q;
    logic [LW-1:0]       line_q;
    logic [LW-1:0]       img;
    logic                busy, last, fail;

    assign busy = state_q == BURST;
    assign last = beat_q == BW'(BEATS - 1);

`ifdef THOR2023_DCFILL_TIMEOUT_EN
    logic [7:0] to_q;

    // Cleared outside BURST (so on every entry) and on each ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_q <= '0;
        else
            to_q <= (busy && !ack_i) ? to_q + 8'd1 : 8'd0;
    end

    assign fail = err_i | (busy & (to_q == 8'(TO_CNT)));
`else
    assign fail = err_i;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_v ? BURST : IDLE;
            BURST:   state_d = fail ? ABORT : (ack_i && last) ? WRITE : BURST;
            WRITE:   state_d = (lines_q > 2'd1) ? BURST : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign req_rdy = state_q == IDLE;
    assign cyc_o   = busy;
    assign stb_o   = busy;
    assign we_o    = 1'b0;
    assign sel_o   = {(BUS_WID/8){busy}};
    assign cti_o   = busy ? (last ? 3'b111 : 3'b010) : 3'b000;
    assign adr_o   = busy ? adr_q + ADR_WID'({beat_q, {OFFB{1'b0}}}) : '0;
    assign wr_dc_o = state_q == WRITE;
    assign done_o  = state_q == DONE;
    assign err_o   = state_q == ABORT;

    // The image is live during WRITE and captured then, so line_o holds through the next burst.
    assign img          = {1'b1, 1'b0, vadr_q, adr_q, buf_q};
    assign line_o       = wr_dc_o ? img : line_q;
    assign update_adr_o = line_o[LINE_WID+ADR_WID +: ADR_WID];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            vadr_q  <= '0;
            beat_q  <= '0;
            lines_q <= '0;
            buf_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (req_v && req_rdy) begin
                adr_q   <= req_adr & AMASK;
                vadr_q  <= req_vadr & AMASK;
                lines_q <= req_span ? 2'd2 : 2'd1;
                beat_q  <= '0;
            end
            if (busy && ack_i && !fail) begin
                buf_q[beat_q*BUS_WID +: BUS_WID] <= dat_i;
                beat_q <= beat_q + 1'b1;
            end
            if (wr_dc_o) begin
                line_q  <= img;
                lines_q <= lines_q - 2'd1;
                beat_q  <= '0;
                if (lines_q > 2'd1) begin
                    adr_q  <= adr_q + LINE_INC;
                    vadr_q <= vadr_q + LINE_INC;
                end
            end
        end
    end
endmodule

// File: tb/tb_thor2023_dcache_line_fill.sv
// tb_thor2023_dcache_line_fill: table-driven bench for the dcache line fill handler
module tb_thor2023_dcache_line_fill;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_v = 1'b0, req_span = 1'b0;
    logic [31:0]  req_adr = '0, req_vadr = '0;
    logic         req_rdy, cyc_o, stb_o, we_o, wr_dc_o, done_o, err_o;
    logic [15:0]  sel_o;
    logic [2:0]   cti_o;
    logic [31:0]  adr_o, update_adr_o;
    logic [127:0] dat_i = '0;
    logic         ack_i = 1'b0, err_i = 1'b0;
    logic [577:0] line_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    thor2023_dcache_line_fill dut (
        .clk(clk), .rst(rst), .req_v(req_v), .req_rdy(req_rdy), .req_adr(req_adr),
        .req_vadr(req_vadr), .req_span(req_span), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .cti_o(cti_o), .adr_o(adr_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
        .line_o(line_o), .update_adr_o(update_adr_o), .wr_dc_o(wr_dc_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] vadr;
        logic        span;
        int          gap;
        int          err_beat;
        logic [31:0] pb0;
        logic [31:0] pb1;
        logic [31:0] vb0;
        logic [31:0] vb1;
        int          nwr;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [577:0] act, input logic [577:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] dat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'h1111_1111};
    endfunction

    function automatic logic [577:0] img(input logic [31:0] pb, input logic [31:0] vb);
        return {1'b1, 1'b0, vb, pb, dat(pb + 32'h30), dat(pb + 32'h20), dat(pb + 32'h10), dat(pb)};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] va, input logic sp);
        @(negedge clk);
        chk("req_rdy_idle", req_rdy, 1);
        req_v = 1; req_adr = a; req_vadr = va; req_span = sp;
        @(negedge clk);
        req_v = 0;
        chk("req_rdy_busy", req_rdy, 0);
    endtask

    task automatic run(input vec_t v, input int idx);
        int bi = 0, li = 0, wc = 0, nwr = 0, k = 1, wr_k = -1;
        logic got_done = 0, got_err = 0;
        logic [31:0] pb, ea;
        issue(v.adr, v.vadr, v.span);
        while (k < 300) begin
            ack_i = 0; err_i = 0;
            if (done_o) begin got_done = 1; break; end
            if (err_o) begin got_err = 1; break; end
            if (wr_dc_o) begin
                chk("line", line_o, nwr == 0 ? img(v.pb0, v.vb0) : img(v.pb1, v.vb1));
                chk("update_adr", update_adr_o, nwr == 0 ? v.vb0 : v.vb1);
                nwr++;
                wr_k = k;
            end
            if (cyc_o) begin
                pb = li == 0 ? v.pb0 : v.pb1;
                ea = pb + 32'(bi * 16);
                chk("adr_o", adr_o, ea);
                chk("cti_o", cti_o, bi == 3 ? 3'b111 : 3'b010);
                chk("bus_ctl", {stb_o, we_o, sel_o}, {1'b1, 1'b0, 16'hffff});
                dat_i = dat(ea);
                if (wc == v.gap) begin
                    wc = 0;
                    if (li * 4 + bi == v.err_beat) err_i = 1;
                    else begin
                        ack_i = 1;
                        bi++;
                        if (bi == 4) begin bi = 0; li++; end
                    end
                end else wc++;
            end
            @(negedge clk);
            k++;
        end
        ack_i = 0; err_i = 0;
        chk($sformatf("v%0d_done", idx), got_done, v.done);
        chk($sformatf("v%0d_err", idx), got_err, v.err);
        chk($sformatf("v%0d_nwr", idx), nwr, v.nwr);
        if (idx == 0) chk("latency", wr_k, 5);
        if (got_done) chk("done_after_wr", k, wr_k + 1);
        @(negedge clk);
        chk("req_rdy_after", req_rdy, 1);
        chk("no_pulses_after", {cyc_o, wr_dc_o, done_o, err_o}, 0);
    endtask

    initial begin
        int k;
        logic seen;
        vecs[0] = '{32'h0000_1234, 32'hABCD_5678, 1'b0, 0, -1, 32'h0000_1200, 32'h0,
                    32'hABCD_5640, 32'h0, 1, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_107C, 32'h0000_107C, 1'b1, 0, -1, 32'h0000_1040, 32'h0000_1080,
                    32'h0000_1040, 32'h0000_1080, 2, 1'b1, 1'b0};
        vecs[2] = '{32'h2000_0FC4, 32'h3000_0FDF, 1'b0, 2, -1, 32'h2000_0FC0, 32'h0,
                    32'h3000_0FC0, 32'h0, 1, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_4010, 32'h0000_4010, 1'b1, 1, 6, 32'h0000_4000, 32'h0000_4040,
                    32'h0000_4000, 32'h0000_4040, 1, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FFC8, 32'h7FFF_FFF0, 1'b1, 0, -1, 32'hFFFF_FFC0, 32'h0000_0000,
                    32'h7FFF_FFC0, 32'h8000_0000, 2, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_8888, 32'h0000_8888, 1'b0, 0, 0, 32'h0000_8880, 32'h0,
                    32'h0000_8880, 32'h0, 0, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_ctl", {req_rdy, cyc_o, stb_o, wr_dc_o, done_o, err_o}, 6'b100000);
        chk("rst_bus", {adr_o, cti_o, sel_o, we_o}, 0);
        chk("rst_line", line_o, 0);
        rst = 1;

        // ack outside BURST must be ignored
        @(negedge clk);
        ack_i = 1;
        repeat (3) @(negedge clk);
        chk("idle_ack_ignored", {req_rdy, cyc_o, wr_dc_o, done_o, err_o}, 5'b10000);
        ack_i = 0;

        for (int i = 0; i < 6; i++) run(vecs[i], i);

        // reset during beat 1: bus drops at once, no pulses, line image cleared
        issue(32'h0000_5000, 32'h0000_5000, 1'b0);
        dat_i = dat(32'h0000_5000);
        ack_i = 1;
        @(negedge clk);
        ack_i = 0;
        chk("beat1_adr", adr_o, 32'h0000_5010);
        #2 rst = 0;
        #1 chk("rst_async_bus", {cyc_o, stb_o}, 2'b00);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | wr_dc_o | done_o | err_o | cyc_o;
        end
        chk("rst_no_pulses", seen, 0);
        rst = 1;
        @(negedge clk);
        chk("rst_rel_rdy", req_rdy, 1);
        chk("rst_rel_line", line_o, 0);

        issue(32'h0000_6000, 32'h0000_6000, 1'b0);
        k = 1;
`ifdef THOR2023_DCFILL_TIMEOUT_EN
        while (k < 400 && !err_o) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_err", err_o, 1);
        chk("timeout_cycle", k, 257);
        chk("timeout_cyc_low", cyc_o, 0);
        @(negedge clk);
        chk("timeout_rdy", req_rdy, 1);
`else
        while (k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("no_timeout_cyc", {cyc_o, err_o}, 2'b10);
        rst = 0;
        #1 rst = 1;
        @(negedge clk);
        chk("no_timeout_rdy", req_rdy, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
